// File: rtl/parking_slot_sensor_if.sv
// Slot sensor bundle: raw sensor inputs and the debounced entry/exit/occupancy outputs.
// The master side drives the sensors; the slave side is the parking_slot_sensor block.
interface parking_slot_sensor_if;
  logic [3:0] sensor_raw;
  logic [3:0] car_entry;
  logic [3:0] car_exit;
  logic [3:0] occupied;
  logic [2:0] free_count;

  modport master (
    output sensor_raw,
    input  car_entry,
    input  car_exit,
    input  occupied,
    input  free_count
  );

  modport slave (
    input  sensor_raw,
    output car_entry,
    output car_exit,
    output occupied,
    output free_count
  );
endinterface

// File: rtl/parking_slot_sensor.sv
// Four-slot occupancy front end: sync, debounce FSM per slot, entry/exit pulses, free count.
// Optional PARKING_SLOT_SENSOR_EXIT_SERIALIZE_EN issues at most one car_exit bit per cycle.
module parking_slot_sensor #(
  parameter int DEBOUNCE_CYCLES = 40_000
) (
  input  logic                  clk,
  input  logic                  reset,
  parking_slot_sensor_if.slave  bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {EMPTY, ARRIVING, OCCUPIED, LEAVING} slot_state_e;

  logic [3:0]    sync1;
  logic [3:0]    s_sync;
  slot_state_e   state_q [4];
  slot_state_e   state_d [4];
  logic [CW-1:0] cnt_q   [4];
  logic [CW-1:0] cnt_d   [4];
  logic [3:0]    entry_d;
  logic [3:0]    exit_req;
  logic [3:0]    occ_d;
  logic [2:0]    free_d;
  logic [3:0]    entry_q;
  logic [3:0]    exit_q;
  logic [3:0]    occ_q;
  logic [2:0]    free_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '0;
      s_sync <= '0;
    end else begin
      sync1  <= bus.sensor_raw;
      s_sync <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        state_q[i] <= EMPTY;
        cnt_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    entry_d  = '0;
    exit_req = '0;
    occ_d    = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        EMPTY: begin
          if (s_sync[i]) begin
            state_d[i] = ARRIVING;
            cnt_d[i]   = '0;
          end
        end
        ARRIVING: begin
          if (!s_sync[i]) begin
            state_d[i] = EMPTY;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = OCCUPIED;
            entry_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        OCCUPIED: begin
          if (!s_sync[i]) begin
            state_d[i] = LEAVING;
            cnt_d[i]   = '0;
          end
        end
        LEAVING: begin
          if (s_sync[i]) begin
            state_d[i] = OCCUPIED;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]  = EMPTY;
            exit_req[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: state_d[i] = EMPTY;
      endcase
      occ_d[i] = (state_d[i] == OCCUPIED) || (state_d[i] == LEAVING);
    end
  end

  // Occupancy is taken from the next state so the sign updates on the transition edge.
  always_comb begin
    free_d = 3'd4;
    for (int i = 0; i < 4; i++) begin
      if (occ_d[i]) free_d = free_d - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q <= '0;
      occ_q   <= '0;
      free_q  <= 3'd4;
    end else begin
      entry_q <= entry_d;
      occ_q   <= occ_d;
      free_q  <= free_d;
    end
  end

`ifdef PARKING_SLOT_SENSOR_EXIT_SERIALIZE_EN
  logic [3:0] pend_q;
  logic [3:0] pend_all;
  logic [3:0] exit_pick;

  // New requests join the mask in the same cycle, so the lowest slot leaves with no extra delay.
  always_comb begin
    pend_all  = pend_q | exit_req;
    exit_pick = pend_all & (~pend_all + 4'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      exit_q <= '0;
    end else begin
      pend_q <= pend_all & ~exit_pick;
      exit_q <= exit_pick;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) exit_q <= '0;
    else       exit_q <= exit_req;
  end
`endif

  assign bus.car_entry  = entry_q;
  assign bus.car_exit   = exit_q;
  assign bus.occupied   = occ_q;
  assign bus.free_count = free_q;

endmodule

// File: tb/tb_parking_slot_sensor.sv
// Scoreboard bench for parking_slot_sensor: directed test-plan scenarios followed by random
// sensor activity, checked against an acceptance-run model of each slot.
module tb_parking_slot_sensor;

  localparam int D    = 4;
  localparam int HMSK = 8191;

  logic clk;
  logic reset;

  parking_slot_sensor_if bus ();

  parking_slot_sensor #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] entry;
    logic [3:0] exit_v;
  } ev_t;

  ev_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Reference model: a slot flips its accepted level after D+1 consecutive edges where the
  // two-edge-delayed sensor disagrees with it; any agreeing edge restarts the run.
  int         cyc        = -1;
  int         last_reset = -100;
  logic [3:0] raw_hist [HMSK+1];
  logic [3:0] acc        = '0;
  int         run [4]    = '{default: 0};
  logic [3:0] pend       = '0;
  logic [3:0] exp_occ    = '0;
  logic [2:0] exp_free   = 3'd4;

  always @(posedge clk) begin
    logic [3:0] s;
    logic [3:0] ent;
    logic [3:0] ext;
    logic [3:0] ex_out;
    int         cnt;
    cyc++;
    raw_hist[cyc & HMSK] = bus.sensor_raw;
    ent = '0;
    ext = '0;
    if (reset) begin
      last_reset = cyc;
      acc  = '0;
      pend = '0;
      for (int i = 0; i < 4; i++) run[i] = 0;
    end else begin
      s = (cyc - 2 > last_reset) ? raw_hist[(cyc - 2) & HMSK] : 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (s[i] != acc[i]) begin
          run[i]++;
          if (run[i] == D + 1) begin
            run[i] = 0;
            if (s[i]) ent[i] = 1'b1;
            else      ext[i] = 1'b1;
            acc[i] = s[i];
          end
        end else begin
          run[i] = 0;
        end
      end
`ifdef PARKING_SLOT_SENSOR_EXIT_SERIALIZE_EN
      pend   = pend | ext;
      ex_out = '0;
      for (int i = 0; i < 4; i++) begin
        if (pend[i] && ex_out == 4'b0000) ex_out[i] = 1'b1;
      end
      pend = pend & ~ex_out;
`else
      ex_out = ext;
`endif
      if ((ent | ex_out) != 4'b0000) sb.push_back('{cyc: cyc, entry: ent, exit_v: ex_out});
    end
    exp_occ = acc;
    cnt = 0;
    for (int i = 0; i < 4; i++) cnt += int'(acc[i]);
    exp_free = 3'(4 - cnt);
  end

  // Monitor: samples on the falling edge and matches every pulse against the scoreboard.
  always @(negedge clk) begin
    logic [7:0] got;
    if (cyc >= 0) begin
      got = {bus.car_entry, bus.car_exit};
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("missed_pulse", 32'(got), 32'({sb[0].entry, sb[0].exit_v}));
        void'(sb.pop_front());
      end
      if (got != 8'h00) begin
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          check("unexpected_pulse", 32'(got), 32'h0);
        end else begin
          check("car_entry", 32'(bus.car_entry), 32'(sb[0].entry));
          check("car_exit", 32'(bus.car_exit), 32'(sb[0].exit_v));
          void'(sb.pop_front());
        end
      end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
        check("missed_pulse", 32'(got), 32'({sb[0].entry, sb[0].exit_v}));
        void'(sb.pop_front());
      end
      check("occupied", 32'(bus.occupied), 32'(exp_occ));
      check("free_count", 32'(bus.free_count), 32'(exp_free));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] bounce [7];
    int         hold [4];
    reset = 1'b1;
    bus.sensor_raw = 4'b0000;
    step(3);
    reset = 1'b0;
    step(2);

    // Clean arrival on slot 1.
    bus.sensor_raw = 4'b0010;
    step(12);

    // Bounce on slot 0, then settle high.
    bounce = '{4'b0011, 4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0010, 4'b0011};
    for (int i = 0; i < 7; i++) begin
      bus.sensor_raw = bounce[i];
      step(1);
    end
    step(12);

    // Departure of slot 2.
    bus.sensor_raw = 4'b0111;
    step(12);
    bus.sensor_raw = 4'b0011;
    step(12);

    // Slots 0, 1, 3 occupied, then all three leave together.
    bus.sensor_raw = 4'b1011;
    step(12);
    bus.sensor_raw = 4'b0000;
    step(14);

    // Mid-debounce reset on slot 3 while the car stays present.
    bus.sensor_raw = 4'b1000;
    step(5);
    pulse_reset();
    step(14);
    bus.sensor_raw = 4'b0000;
    step(12);

    // Full lot, held.
    bus.sensor_raw = 4'b1111;
    step(25);
    bus.sensor_raw = 4'b0000;
    step(14);

    // Random activity: each slot holds a level for a random span, with rare resets.
    for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 3 * D);
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] nxt;
      nxt = bus.sensor_raw;
      for (int i = 0; i < 4; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          nxt[i]  = ~nxt[i];
          hold[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, D + 1)
                                                 : $urandom_range(D + 2, 4 * D);
        end
      end
      bus.sensor_raw = nxt;
      reset = ($urandom_range(0, 499) == 0);
      step(1);
    end
    reset = 1'b0;
    bus.sensor_raw = 4'b0000;
    step(20);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
